// File: rtl/osd_event_arbiter_if.sv
// Packetizer-side bus of osd_event_arbiter: event/payload toward the packetizer,
// word requests and consume strobe back from it.
interface osd_event_arbiter_if #(
    parameter int MAX_DATA_NUM_WORDS = 8
);
    localparam int NW = $clog2(MAX_DATA_NUM_WORDS + 1);
    localparam int IW = $clog2(MAX_DATA_NUM_WORDS);

    logic          event_available;
    logic          overflow;
    logic [NW-1:0] data_num_words;
    logic [15:0]   data;
    logic [IW-1:0] data_req_idx;
    logic          data_req_valid;
    logic          event_consumed;

    modport master (
        output event_available,
        output overflow,
        output data_num_words,
        output data,
        input  data_req_idx,
        input  data_req_valid,
        input  event_consumed
    );

    modport slave (
        input  event_available,
        input  overflow,
        input  data_num_words,
        input  data,
        output data_req_idx,
        output data_req_valid,
        output event_consumed
    );
endinterface

// File: rtl/osd_event_arbiter.sv
// Shares one osd_event_packetization instance between NUM_SRC sources; dropped events are
// counted and reported as overflow packets. Define OSD_EVENT_ARB_FIXED_PRIORITY_EN for fixed priority.
module osd_event_arbiter #(
    parameter  int NUM_SRC            = 4,
    parameter  int MAX_DATA_NUM_WORDS = 8,
    localparam int NW                 = $clog2(MAX_DATA_NUM_WORDS + 1),
    localparam int IW                 = $clog2(MAX_DATA_NUM_WORDS),
    localparam int GW                 = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    src_event_available,
    input  logic [NUM_SRC*NW-1:0] src_data_num_words,
    input  logic [NUM_SRC*16-1:0] src_data,
    input  logic [NUM_SRC-1:0]    src_drop,
    output logic [NUM_SRC-1:0]    src_event_consumed,
    output logic [IW-1:0]         src_data_req_idx,
    output logic [NUM_SRC-1:0]    src_data_req_valid,
    osd_event_arbiter_if.master   pkt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVT  = 2'd1,
        ST_OVF  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
`ifndef OSD_EVENT_ARB_FIXED_PRIORITY_EN
    logic [GW-1:0]  last_grant_q, last_grant_d;
`endif
    logic [15:0]    ovf_cnt_q, ovf_cnt_d;
    logic [15:0]    ovf_snap_q, ovf_snap_d;

    logic [GW-1:0]  pick_s;
    logic [GW-1:0]  cand_s;
    logic [GW:0]    drop_cnt_s;
    logic [15:0]    ovf_base_s;
    logic [16:0]    ovf_sum_s;
    logic [NW-1:0]  nw_arr_s   [NUM_SRC];
    logic [15:0]    data_arr_s [NUM_SRC];

    function automatic logic [GW:0] popcount(input logic [NUM_SRC-1:0] v);
        logic [GW:0] c;
        c = {(GW+1){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            c = c + {{GW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            nw_arr_s[i]   = src_data_num_words[i*NW +: NW];
            data_arr_s[i] = src_data[i*16 +: 16];
        end
    end

    // Next source to serve; later loop iterations win, so the loop runs from lowest to highest priority.
    always_comb begin
        pick_s = {GW{1'b0}};
        cand_s = {GW{1'b0}};
`ifdef OSD_EVENT_ARB_FIXED_PRIORITY_EN
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            cand_s = GW'(i);
            if (src_event_available[cand_s]) begin
                pick_s = cand_s;
            end else begin
                pick_s = pick_s;
            end
        end
`else
        for (int off = NUM_SRC; off >= 1; off--) begin
            cand_s = GW'((int'(last_grant_q) + off) % NUM_SRC);
            if (src_event_available[cand_s]) begin
                pick_s = cand_s;
            end else begin
                pick_s = pick_s;
            end
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
`ifndef OSD_EVENT_ARB_FIXED_PRIORITY_EN
        last_grant_d = last_grant_q;
`endif
        ovf_snap_d   = ovf_snap_q;
        ovf_base_s   = ovf_cnt_q;
        drop_cnt_s   = popcount(src_drop);
        case (state_q)
            ST_IDLE: begin
                if (ovf_cnt_q != 16'h0000) begin
                    ovf_snap_d = ovf_cnt_q;
                    state_d    = ST_OVF;
                end else if (|src_event_available) begin
                    grant_d = pick_s;
                    state_d = ST_EVT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVT: begin
                if (pkt.event_consumed) begin
`ifndef OSD_EVENT_ARB_FIXED_PRIORITY_EN
                    last_grant_d = grant_q;
`endif
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EVT;
                end
            end
            ST_OVF: begin
                // snap never exceeds the counter, so the subtraction cannot underflow
                if (pkt.event_consumed) begin
                    ovf_base_s = ovf_cnt_q - ovf_snap_q;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_OVF;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ovf_sum_s = {1'b0, ovf_base_s} + 17'(drop_cnt_s);
        ovf_cnt_d = ovf_sum_s[16] ? 16'hFFFF : ovf_sum_s[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= {GW{1'b0}};
`ifndef OSD_EVENT_ARB_FIXED_PRIORITY_EN
            last_grant_q <= GW'(NUM_SRC - 1);
`endif
            ovf_cnt_q    <= 16'h0000;
            ovf_snap_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
`ifndef OSD_EVENT_ARB_FIXED_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
            ovf_cnt_q    <= ovf_cnt_d;
            ovf_snap_q   <= ovf_snap_d;
        end
    end

    // Consume pulse is suppressed during reset so an aborted packet never completes.
    always_comb begin
        pkt.event_available = 1'b0;
        pkt.overflow        = 1'b0;
        pkt.data_num_words  = {NW{1'b0}};
        pkt.data            = 16'h0000;
        src_data_req_valid  = {NUM_SRC{1'b0}};
        src_event_consumed  = {NUM_SRC{1'b0}};
        case (state_q)
            ST_IDLE: begin
                pkt.event_available = 1'b0;
            end
            ST_EVT: begin
                pkt.event_available = src_event_available[grant_q];
                pkt.data_num_words  = nw_arr_s[grant_q];
                pkt.data            = data_arr_s[grant_q];
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant_q == GW'(i)) begin
                        src_data_req_valid[i] = pkt.data_req_valid;
                        src_event_consumed[i] = pkt.event_consumed & ~rst;
                    end else begin
                        src_data_req_valid[i] = 1'b0;
                        src_event_consumed[i] = 1'b0;
                    end
                end
            end
            ST_OVF: begin
                pkt.event_available = 1'b1;
                pkt.overflow        = 1'b1;
                pkt.data_num_words  = NW'(1);
                pkt.data            = ovf_snap_q;
            end
            default: begin
                pkt.event_available = 1'b0;
            end
        endcase
    end

    assign src_data_req_idx = pkt.data_req_idx;

    evt_hold_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_EVT) |-> src_event_available[grant_q]);

endmodule
